// File: rtl/key_time_set_ctrl_pkg.sv
// Shared definitions for the clock-setting controller: key codes, FSM encoding,
// per-digit limits and BCD digit access helpers.
package key_ctrl_pkg;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_EDIT = 3'b010,
    ST_LOAD = 3'b100
  } state_t;

  localparam logic [3:0] LIM_H1    = 4'd2;
  localparam logic [3:0] LIM_H0    = 4'd9;
  localparam logic [3:0] LIM_H0_20 = 4'd3;
  localparam logic [3:0] LIM_M1    = 4'd5;
  localparam logic [3:0] LIM_M0    = 4'd9;
  localparam logic [3:0] LIM_S1    = 4'd5;
  localparam logic [3:0] LIM_S0    = 4'd9;

  localparam logic [2:0] CUR_H1 = 3'd0;
  localparam logic [2:0] CUR_H0 = 3'd1;
  localparam logic [2:0] CUR_M1 = 3'd2;
  localparam logic [2:0] CUR_M0 = 3'd3;
  localparam logic [2:0] CUR_S1 = 3'd4;
  localparam logic [2:0] CUR_S0 = 3'd5;

  // Cursor 0 addresses the most significant nibble (H1) of {H1,H0,M1,M0,S1,S0}.
  function automatic logic [3:0] get_digit(input logic [23:0] t, input logic [2:0] idx);
    case (idx)
      CUR_H1:  get_digit = t[23:20];
      CUR_H0:  get_digit = t[19:16];
      CUR_M1:  get_digit = t[15:12];
      CUR_M0:  get_digit = t[11:8];
      CUR_S1:  get_digit = t[7:4];
      default: get_digit = t[3:0];
    endcase
  endfunction

  function automatic logic [23:0] put_digit(input logic [23:0] t, input logic [2:0] idx,
                                            input logic [3:0] d);
    put_digit = t;
    case (idx)
      CUR_H1:  put_digit[23:20] = d;
      CUR_H0:  put_digit[19:16] = d;
      CUR_M1:  put_digit[15:12] = d;
      CUR_M0:  put_digit[11:8]  = d;
      CUR_S1:  put_digit[7:4]   = d;
      default: put_digit[3:0]   = d;
    endcase
  endfunction

  function automatic logic [3:0] digit_limit(input logic [2:0] idx, input logic [3:0] h1);
    case (idx)
      CUR_H1:  digit_limit = LIM_H1;
      CUR_H0:  digit_limit = (h1 == LIM_H1) ? LIM_H0_20 : LIM_H0;
      CUR_M1:  digit_limit = LIM_M1;
      CUR_M0:  digit_limit = LIM_M0;
      CUR_S1:  digit_limit = LIM_S1;
      default: digit_limit = LIM_S0;
    endcase
  endfunction

endpackage

// File: rtl/key_time_set_ctrl_idle_timer.sv
// Inactivity down-counter: reload arms it, it counts while run is high and
// flags expiry on the last idle cycle unless a reload arrives in that cycle.
module key_idle_timer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic reload,
  input  logic run,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (reload) begin
      count_q <= LOAD_VAL;
    end else if (!run) begin
      count_q <= '0;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = run && !reload && (count_q == W'(1));

endmodule

// File: rtl/key_time_set_ctrl.sv
// Keypad-driven HH:MM:SS setting controller: edits a BCD buffer digit by digit
// and pulses SET_LOAD on commit.
module key_time_set_ctrl
  import key_ctrl_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  KEY_Value,
  input  logic        Value_en,
  input  logic [23:0] CUR_TIME,
  output logic [23:0] SET_TIME,
  output logic        SET_LOAD,
  output logic        EDIT_MODE,
  output logic [2:0]  CURSOR,
  output logic        KEY_REJECT
);

  state_t      state_q, state_d;
  logic [23:0] time_q, time_d;
  logic [2:0]  cur_q, cur_d, cur_inc, cur_dec;
  logic        rej_q, rej_d, edit_q, load_q;
  logic        expire;
  logic [3:0]  lim;
  logic        force_h0;

  key_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .reload (Value_en),
    .run    (state_q == ST_EDIT),
    .expire (expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      cur_q   <= CUR_H1;
      rej_q   <= 1'b0;
      edit_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      cur_q   <= cur_d;
      rej_q   <= rej_d;
      edit_q  <= (state_d != ST_IDLE);
      load_q  <= (state_d == ST_LOAD);
    end
  end

  // A key in the expiry cycle wins: the timer suppresses expire on reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Value_en && KEY_Value == KEY_A) state_d = ST_EDIT;
      ST_EDIT: begin
        if (Value_en) begin
          if (KEY_Value == KEY_B)      state_d = ST_LOAD;
          else if (KEY_Value == KEY_C) state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    time_d   = time_q;
    cur_d    = cur_q;
    rej_d    = 1'b0;
    cur_inc  = (cur_q == CUR_S0) ? CUR_H1 : cur_q + 3'd1;
    cur_dec  = (cur_q == CUR_H1) ? CUR_S0 : cur_q - 3'd1;
    lim      = digit_limit(cur_q, get_digit(time_q, CUR_H1));
    force_h0 = (cur_q == CUR_H1) && (KEY_Value == LIM_H1) &&
               (get_digit(time_q, CUR_H0) > LIM_H0_20);
    case (state_q)
      ST_IDLE: begin
        if (Value_en) begin
          if (KEY_Value == KEY_A) begin
            time_d = CUR_TIME;
            cur_d  = CUR_H1;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_EDIT: begin
        if (Value_en) begin
          if (KEY_Value <= KEY_DIGIT_MAX) begin
            if (KEY_Value <= lim) begin
              time_d = force_h0
                     ? put_digit(put_digit(time_q, cur_q, KEY_Value), CUR_H0, LIM_H0_20)
                     : put_digit(time_q, cur_q, KEY_Value);
              cur_d  = cur_inc;
            end else begin
              rej_d = 1'b1;
            end
          end else begin
            case (KEY_Value)
              KEY_A: rej_d = 1'b1;
              KEY_D: cur_d = cur_dec;
              KEY_E: cur_d = cur_inc;
              KEY_F: begin
                time_d = '0;
                cur_d  = CUR_H1;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign SET_TIME   = time_q;
  assign SET_LOAD   = load_q;
  assign EDIT_MODE  = edit_q;
  assign CURSOR     = cur_q;
  assign KEY_REJECT = rej_q;

endmodule

// File: tb/tb_key_time_set_ctrl.sv
// Directed bench for key_time_set_ctrl with hand-computed expectations.
module tb_key_time_set_ctrl;

  logic        CLK;
  logic        RST;
  logic [3:0]  KEY_Value;
  logic        Value_en;
  logic [23:0] CUR_TIME;
  logic [23:0] SET_TIME;
  logic        SET_LOAD;
  logic        EDIT_MODE;
  logic [2:0]  CURSOR;
  logic        KEY_REJECT;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;
  int cnt;

  key_time_set_ctrl #(.TIMEOUT_CYCLES(24'd100)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY_Value  (KEY_Value),
    .Value_en   (Value_en),
    .CUR_TIME   (CUR_TIME),
    .SET_TIME   (SET_TIME),
    .SET_LOAD   (SET_LOAD),
    .EDIT_MODE  (EDIT_MODE),
    .CURSOR     (CURSOR),
    .KEY_REJECT (KEY_REJECT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (SET_LOAD) load_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe one key for one cycle; returns at the negedge where its effect is visible.
  task automatic key_in(input logic [3:0] k);
    @(negedge CLK);
    KEY_Value = k;
    Value_en  = 1'b1;
    @(negedge CLK);
    Value_en  = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [23:0] t, input logic [2:0] c,
                            input logic ed, input logic ld, input logic rj);
    check_val({tag, ".time"}, 32'(SET_TIME), 32'(t));
    check_val({tag, ".cur"},  32'(CURSOR), 32'(c));
    check_val({tag, ".edit"}, 32'(EDIT_MODE), 32'(ed));
    check_val({tag, ".load"}, 32'(SET_LOAD), 32'(ld));
    check_val({tag, ".rej"},  32'(KEY_REJECT), 32'(rj));
  endtask

  initial begin
    RST       = 1'b1;
    KEY_Value = 4'd0;
    Value_en  = 1'b0;
    CUR_TIME  = 24'h123456;
    repeat (3) @(negedge CLK);
    check_outs("reset", 24'h000000, 3'd0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;

    // Enter, edit, commit
    key_in(4'hA);
    check_outs("enter", 24'h123456, 3'd0, 1'b1, 1'b0, 1'b0);
    key_in(4'd1); key_in(4'd9); key_in(4'd0);
    check_outs("edit3", 24'h190456, 3'd3, 1'b1, 1'b0, 1'b0);
    key_in(4'd0); key_in(4'd4); key_in(4'd5);
    check_outs("edit6", 24'h190045, 3'd0, 1'b1, 1'b0, 1'b0);
    key_in(4'hB);
    check_outs("commit", 24'h190045, 3'd0, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    check_outs("post_commit", 24'h190045, 3'd0, 1'b0, 1'b0, 1'b0);
    check_val("load_cnt1", 32'(load_cnt), 32'd1);

    // Digit limits
    key_in(4'hA);
    key_in(4'hF);
    check_outs("clear", 24'h000000, 3'd0, 1'b1, 1'b0, 1'b0);
    key_in(4'd3);
    check_outs("rej_h1", 24'h000000, 3'd0, 1'b1, 1'b0, 1'b1);
    key_in(4'd1); key_in(4'd7);
    check_outs("h17", 24'h170000, 3'd2, 1'b1, 1'b0, 1'b0);
    key_in(4'hD); key_in(4'hD); key_in(4'd2);
    check_outs("force_h0", 24'h230000, 3'd1, 1'b1, 1'b0, 1'b0);
    key_in(4'd4);
    check_outs("rej_h0", 24'h230000, 3'd1, 1'b1, 1'b0, 1'b1);
    key_in(4'hE); key_in(4'd6);
    check_outs("rej_m1", 24'h230000, 3'd2, 1'b1, 1'b0, 1'b1);
    key_in(4'hA);
    check_outs("rej_a_edit", 24'h230000, 3'd2, 1'b1, 1'b0, 1'b1);
    key_in(4'hC);
    check_outs("cancel1", 24'h230000, 3'd2, 1'b0, 1'b0, 1'b0);

    // Cursor wrap
    key_in(4'hA); key_in(4'hD);
    check_val("wrap_left", 32'(CURSOR), 32'd5);
    key_in(4'hE);
    check_val("wrap_right", 32'(CURSOR), 32'd0);
    key_in(4'd0); key_in(4'd0); key_in(4'd0);
    check_val("cur3", 32'(CURSOR), 32'd3);
    key_in(4'd0); key_in(4'd0); key_in(4'd0);
    check_outs("wrap_six", 24'h000000, 3'd0, 1'b1, 1'b0, 1'b0);
    key_in(4'hC);

    // Timeout: 100 idle cycles after the key
    key_in(4'hA);
    cnt = 0;
    while (EDIT_MODE && cnt < 300) begin
      @(negedge CLK);
      cnt++;
    end
    check_val("timeout", 32'(cnt), 32'd100);
    check_outs("timeout_outs", 24'h123456, 3'd0, 1'b0, 1'b0, 1'b0);

    // Key on idle cycle 99 restarts the count
    key_in(4'hA);
    repeat (97) @(negedge CLK);
    key_in(4'hE);
    check_outs("late_key", 24'h123456, 3'd1, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    while (EDIT_MODE && cnt < 300) begin
      @(negedge CLK);
      cnt++;
    end
    check_val("timeout_restart", 32'(cnt), 32'd100);
    check_val("load_cnt_to", 32'(load_cnt), 32'd1);

    // Cancel with a rejected digit
    key_in(4'hA); key_in(4'd5);
    check_outs("rej_5", 24'h123456, 3'd0, 1'b1, 1'b0, 1'b1);
    key_in(4'hC);
    check_outs("cancel2", 24'h123456, 3'd0, 1'b0, 1'b0, 1'b0);

    // Keys during LOAD are dropped without reject
    key_in(4'hA); key_in(4'd2);
    @(negedge CLK);
    KEY_Value = 4'hB;
    Value_en  = 1'b1;
    @(negedge CLK);
    KEY_Value = 4'd7;
    check_outs("load_cycle", 24'h223456, 3'd1, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    Value_en = 1'b0;
    check_outs("load_drop", 24'h223456, 3'd1, 1'b0, 1'b0, 1'b0);
    check_val("load_cnt2", 32'(load_cnt), 32'd2);

    // Reset mid-edit, with a commit key in the same cycle
    key_in(4'hA); key_in(4'd1);
    check_outs("pre_rst", 24'h123456, 3'd1, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    RST       = 1'b1;
    KEY_Value = 4'hB;
    Value_en  = 1'b1;
    @(negedge CLK);
    check_outs("mid_rst", 24'h000000, 3'd0, 1'b0, 1'b0, 1'b0);
    RST      = 1'b0;
    Value_en = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("load_cnt_rst", 32'(load_cnt), 32'd2);

    // Non-A key in IDLE
    key_in(4'd7);
    check_outs("idle_rej", 24'h000000, 3'd0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    check_val("idle_rej_pulse", 32'(KEY_REJECT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
